// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - shared Fibonacci stream definitions: width, checker states, generator seeds
package fibo_pkg;

    localparam int FIBO_W = 8;

    typedef enum logic [1:0] {
        HUNT0  = 2'd0,
        HUNT1  = 2'd1,
        LOCKED = 2'd2
    } fibo_state_e;

    // Generator reset seed pair; the first advance after reset emits SEED_A + SEED_B.
    localparam logic [FIBO_W-1:0] SEED_A = 8'h00;
    localparam logic [FIBO_W-1:0] SEED_B = 8'h01;

endpackage

// File: rtl/fibo_stream_checker_if.sv
// rtl/fibo_stream_checker_if.sv - per-cycle generator sample bundle (qualifier, hold bit, data)
interface fibo_stream_checker_if
    import fibo_pkg::*;
#(
    parameter int W = FIBO_W
) ();

    logic         in_valid;
    logic         in_hold;
    logic [W-1:0] in_data;

    modport master (
        output in_valid,
        output in_hold,
        output in_data
    );

    modport slave (
        input in_valid,
        input in_hold,
        input in_data
    );

endinterface

// File: rtl/fibo_stream_checker_sat_counter.sv
// rtl/fibo_stream_checker_sat_counter.sv - saturating event counter with priority clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fibo_stream_checker.sv
// rtl/fibo_stream_checker.sv - locks onto a mod-2^W Fibonacci stream and flags per-sample match/error
module fibo_stream_checker
    import fibo_pkg::*;
#(
    parameter int W           = FIBO_W,
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fibo_stream_checker_if.slave  s,
    input  logic                  clr_cnt,
    output logic                  locked,
    output logic                  match_p,
    output logic                  err_p,
    output logic [W-1:0]          expected,
    output logic [CNT_W-1:0]      match_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam logic [1:0] ST_HUNT0  = HUNT0;
    localparam logic [1:0] ST_HUNT1  = HUNT1;
    localparam logic [1:0] ST_LOCKED = LOCKED;

    localparam int MISS_W = $clog2(LOSS_THRESH + 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

    logic [1:0]        state;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [MISS_W-1:0] miss;

    logic [W-1:0] want;
    logic         chk;
    logic         chk_match;
    logic         chk_err;

    // A hold sample must repeat the last accepted value; an advance must equal the prediction.
    always_comb begin
        want      = s.in_hold ? a : b;
        chk       = s.in_valid && (state == ST_LOCKED);
        chk_match = chk && (s.in_data == want);
        chk_err   = chk && (s.in_data != want);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_HUNT0;
            a       <= '0;
            b       <= '0;
            miss    <= '0;
            match_p <= 1'b0;
            err_p   <= 1'b0;
        end else begin
            match_p <= chk_match;
            err_p   <= chk_err;
            if (s.in_valid) begin
                case (state)
                    ST_HUNT0: begin
                        a     <= s.in_data;
                        state <= ST_HUNT1;
                    end
                    ST_HUNT1: begin
                        a <= s.in_data;
                        if (!s.in_hold) begin
                            b     <= a + s.in_data;
                            state <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        // Prediction free-runs on mismatches so a single glitch does not desync.
                        if (!s.in_hold) begin
                            a <= b;
                            b <= a + b;
                        end
                        if (chk_match) begin
                            miss <= '0;
                        end else if (miss == MISS_LAST) begin
                            miss  <= '0;
                            state <= ST_HUNT0;
                        end else begin
                            miss <= miss + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_HUNT0;
                        miss  <= '0;
                    end
                endcase
            end
        end
    end

    assign locked   = (state == ST_LOCKED);
    assign expected = b;

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (chk_match),
        .clr   (clr_cnt),
        .count (match_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (chk_err),
        .clr   (clr_cnt),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_fibo_stream_checker.sv
// tb/tb_fibo_stream_checker.sv - scoreboard bench: directed plan plus randomized generator streams
module tb_fibo_stream_checker;
    import fibo_pkg::*;

    localparam int LOSS = 3;

    logic clk = 1'b0;
    logic rst;
    logic clr_cnt;
    always #5 clk = ~clk;

    fibo_stream_checker_if #(.W(8)) sif ();

    logic        locked, match_p, err_p;
    logic [7:0]  expected;
    logic [15:0] match_cnt, err_cnt;
    logic        locked4, match_p4, err_p4;
    logic [7:0]  expected4;
    logic [3:0]  match_cnt4, err_cnt4;

    fibo_stream_checker #(.W(8), .CNT_W(16), .LOSS_THRESH(LOSS)) dut (
        .clk(clk), .rst(rst), .s(sif), .clr_cnt(clr_cnt),
        .locked(locked), .match_p(match_p), .err_p(err_p), .expected(expected),
        .match_cnt(match_cnt), .err_cnt(err_cnt)
    );

    fibo_stream_checker #(.W(8), .CNT_W(4), .LOSS_THRESH(LOSS)) dut4 (
        .clk(clk), .rst(rst), .s(sif), .clr_cnt(clr_cnt),
        .locked(locked4), .match_p(match_p4), .err_p(err_p4), .expected(expected4),
        .match_cnt(match_cnt4), .err_cnt(err_cnt4)
    );

    typedef struct packed {
        logic        locked;
        logic        mp;
        logic        ep;
        logic [7:0]  exp;
        logic [15:0] mc;
        logic [15:0] ec;
        logic [3:0]  mc4;
        logic [3:0]  ec4;
    } rec_t;

    rec_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: spec rules in plain integer arithmetic.
    int m_mode, m_a, m_b, m_miss, m_mc, m_ec, m_mc4, m_ec4;

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(bit r, bit v, bit h, int d, bit c);
        bit   mp, ep;
        int   want, nb;
        rec_t e;
        mp = 0;
        ep = 0;
        if (r) begin
            m_mode = 0; m_a = 0; m_b = 0; m_miss = 0;
            m_mc = 0; m_ec = 0; m_mc4 = 0; m_ec4 = 0;
        end else begin
            if (v) begin
                if (m_mode == 0) begin
                    m_a = d;
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    if (!h) begin
                        m_b = (m_a + d) % 256;
                        m_mode = 2;
                    end
                    m_a = d;
                end else begin
                    want = h ? m_a : m_b;
                    if (d == want) mp = 1; else ep = 1;
                    if (!h) begin
                        nb = (m_a + m_b) % 256;
                        m_a = m_b;
                        m_b = nb;
                    end
                    if (mp) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss == LOSS) begin
                            m_miss = 0;
                            m_mode = 0;
                        end
                    end
                end
            end
            if (c) begin
                m_mc = 0; m_ec = 0; m_mc4 = 0; m_ec4 = 0;
            end else begin
                m_mc  = sat(m_mc  + int'(mp), 65535);
                m_ec  = sat(m_ec  + int'(ep), 65535);
                m_mc4 = sat(m_mc4 + int'(mp), 15);
                m_ec4 = sat(m_ec4 + int'(ep), 15);
            end
        end
        e.locked = (m_mode == 2);
        e.mp  = mp;
        e.ep  = ep;
        e.exp = 8'(m_b);
        e.mc  = 16'(m_mc);
        e.ec  = 16'(m_ec);
        e.mc4 = 4'(m_mc4);
        e.ec4 = 4'(m_ec4);
        q.push_back(e);
    endtask

    task automatic cyc(bit r, bit v, bit h, int d, bit c);
        @(negedge clk);
        rst          = r;
        sif.in_valid = v;
        sif.in_hold  = h;
        sif.in_data  = 8'(d);
        clr_cnt      = c;
        model_step(r, v, h, d, c);
    endtask

    task automatic send(int d, bit h, bit c = 1'b0);
        cyc(1'b0, 1'b1, h, d, c);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic spot(string n, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", n, act, req, $time);
        end
    endtask

    // Monitor: every cycle produces one output record.
    always @(posedge clk) begin
        rec_t e, act;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = '{locked, match_p, err_p, expected, match_cnt, err_cnt, match_cnt4, err_cnt4};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL sb: got lk=%0b mp=%0b ep=%0b exp=%0d mc=%0d ec=%0d mc4=%0d ec4=%0d want lk=%0b mp=%0b ep=%0b exp=%0d mc=%0d ec=%0d mc4=%0d ec4=%0d at %0t",
                         act.locked, act.mp, act.ep, act.exp, act.mc, act.ec, act.mc4, act.ec4,
                         e.locked, e.mp, e.ep, e.exp, e.mc, e.ec, e.mc4, e.ec4, $time);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int seq[];
        int ga, gb, nv;
        rst = 1'b1; clr_cnt = 1'b0;
        sif.in_valid = 1'b0; sif.in_hold = 1'b0; sif.in_data = '0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 55, 1);
        settle();
        spot("reset_locked", int'(locked), 0);
        spot("reset_expected", int'(expected), 0);
        spot("reset_match_cnt", int'(match_cnt), 0);

        // Clean lock
        send(0, 1);
        seq = '{1, 1, 2, 3, 5, 8};
        foreach (seq[i]) send(seq[i], 0);
        settle();
        spot("lock_match_cnt", int'(match_cnt), 5);
        spot("lock_err_cnt", int'(err_cnt), 0);
        spot("lock_expected", int'(expected), 13);
        spot("lock_locked", int'(locked), 1);

        // Hold cycles
        send(8, 1); send(8, 1); send(13, 0);
        settle();
        spot("hold_expected", int'(expected), 21);
        spot("hold_match_cnt", int'(match_cnt), 8);
        send(9, 1);
        settle();
        spot("hold_err_p", int'(err_p), 1);
        spot("hold_err_cnt", int'(err_cnt), 1);
        spot("hold_locked", int'(locked), 1);

        // Wrap-around
        seq = '{21, 34, 55, 89, 144, 233, 121, 98};
        foreach (seq[i]) send(seq[i], 0);
        settle();
        spot("wrap_expected", int'(expected), 219);

        // Loss of lock
        send(7, 0); send(7, 0);
        settle();
        spot("loss_still_locked", int'(locked), 1);
        send(7, 0);
        settle();
        spot("loss_locked", int'(locked), 0);
        spot("loss_err_cnt", int'(err_cnt), 4);
        send(5, 0); send(8, 0);
        settle();
        spot("relock_locked", int'(locked), 1);
        spot("relock_expected", int'(expected), 13);

        // Valid gating
        for (int i = 0; i < 4; i++) cyc(0, 0, i[0], 200 + i, 0);
        settle();
        spot("gate_expected", int'(expected), 13);
        spot("gate_match_p", int'(match_p), 0);

        // Clear has priority over same-cycle increment
        send(13, 0, 1);
        settle();
        spot("clr_match_p", int'(match_p), 1);
        spot("clr_match_cnt", int'(match_cnt), 0);

        // Mid-lock reset
        cyc(1, 1, 0, 21, 0);
        settle();
        spot("rst_locked", int'(locked), 0);
        spot("rst_expected", int'(expected), 0);
        spot("rst_err_cnt", int'(err_cnt), 0);

        // Degenerate 0,0 stream and 4-bit saturation
        send(0, 1); send(0, 0);
        for (int i = 0; i < 20; i++) send(0, 0);
        settle();
        spot("zero_locked", int'(locked), 1);
        spot("zero_expected", int'(expected), 0);
        spot("zero_match_cnt", int'(match_cnt), 20);
        spot("sat4_match_cnt", int'(match_cnt4), 15);

        // Randomized generator streams
        for (int burst = 0; burst < 40; burst++) begin
            if (burst == 0) begin
                ga = SEED_A; gb = SEED_B;
            end else if (burst == 1) begin
                ga = 0; gb = 0;
            end else begin
                ga = $urandom_range(0, 255); gb = $urandom_range(0, 255);
            end
            if ($urandom_range(0, 9) == 0) cyc(1, 0, 0, 0, 0);
            send(ga, $urandom_range(0, 1));
            send(gb, 0);
            for (int k = 0; k < 30; k++) begin
                bit c;
                c = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    cyc(0, 0, $urandom_range(0, 1), $urandom_range(0, 255), c);
                end else if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 15) == 0) send($urandom_range(0, 255), 1, c);
                    else send(gb, 1, c);
                end else begin
                    nv = (ga + gb) % 256;
                    ga = gb;
                    gb = nv;
                    if ($urandom_range(0, 15) == 0) send($urandom_range(0, 255), 0, c);
                    else send(nv, 0, c);
                end
            end
        end

        cyc(0, 0, 0, 0, 0);
        settle();
        settle();
        spot("sb_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
